// File: rtl/exec_run_controller.sv
// exec_run_controller: run/step/halt sequencer for the five-stage pipeline.
// Consumes debugger commands (RUN, STEP, STOP) and produces the global
// pipeline advance enable and the fetch enable. Execution stops on a HALT
// retiring in WB, on a user STOP, or on an optional PC breakpoint. Before
// stopping, the in-flight instructions are drained.
//
// Build option: define EXEC_CTRL_BREAKPOINT_EN to include the PC breakpoint
// comparator. Without it, i_bp_en / i_bp_addr are ignored and cause 10 is
// never reported.
module exec_run_controller #(
    parameter int SIZE         = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    output logic                 o_cmd_err,
    input  logic [SIZE-1:0]      i_pc,
    input  logic                 i_halt_wb,
    input  logic                 i_bp_en,
    input  logic [SIZE-1:0]      i_bp_addr,
    output logic                 o_pipe_en,
    output logic                 o_fetch_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_halt_cause,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam logic [1:0] CAUSE_HALT = 2'b00;
    localparam logic [1:0] CAUSE_STEP = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_USER = 2'b11;

    // The drain counter is loaded with the index of the last drain cycle and
    // counts down to zero, so DRAIN lasts exactly DRAIN_CYCLES cycles.
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] drain_cnt;
    logic [3:0] drain_cnt_next;
    logic [1:0] cause;
    logic [1:0] cause_next;
    logic       skip_bp;
    logic       skip_bp_next;
    logic       err_next;
    logic       clear_cnt;
    logic       bp_match;

    logic cmd_run;
    logic cmd_step;
    logic cmd_stop;
    logic cmd_any;

    assign cmd_run  = i_cmd_valid && (i_cmd == CMD_RUN);
    assign cmd_step = i_cmd_valid && (i_cmd == CMD_STEP);
    assign cmd_stop = i_cmd_valid && (i_cmd == CMD_STOP);
    assign cmd_any  = cmd_run || cmd_step || cmd_stop;

`ifdef EXEC_CTRL_BREAKPOINT_EN
    // Breakpoint fires only while fetching in RUN; skip_bp masks the first
    // RUN cycle after resuming from a breakpoint stop so the stopped
    // instruction can be fetched.
    assign bp_match = (state == S_RUN) && o_fetch_en && i_bp_en &&
                      (i_pc == i_bp_addr) && !skip_bp;
`else
    assign bp_match = 1'b0;

    logic unused_bp;
    assign unused_bp = &{1'b0, i_bp_en, i_bp_addr, i_pc, skip_bp};
`endif

    // State register and sequencing bookkeeping (drain counter, cause, resume mask).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            drain_cnt <= 4'd0;
            cause     <= CAUSE_HALT;
            skip_bp   <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            cause     <= cause_next;
            skip_bp   <= skip_bp_next;
        end
    end

    // Next-state logic: command handling and stop-event priority.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        cause_next     = cause;
        skip_bp_next   = skip_bp;
        err_next       = 1'b0;
        clear_cnt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_run) begin
                    state_next = S_RUN;
                    clear_cnt  = 1'b1;
                end else if (cmd_step) begin
                    state_next = S_STEP;
                    clear_cnt  = 1'b1;
                end else if (cmd_stop) begin
                    err_next = 1'b1;
                end
            end

            S_RUN: begin
                // The resume mask only ever covers one RUN cycle.
                skip_bp_next = 1'b0;
                if (i_halt_wb) begin
                    state_next = S_DONE;
                    cause_next = CAUSE_HALT;
                end else if (cmd_stop) begin
                    state_next     = S_DRAIN;
                    cause_next     = CAUSE_USER;
                    drain_cnt_next = DRAIN_LAST;
                end else if (bp_match) begin
                    state_next     = S_DRAIN;
                    cause_next     = CAUSE_BP;
                    drain_cnt_next = DRAIN_LAST;
                end
                if (cmd_run || cmd_step) begin
                    err_next = 1'b1;
                end
            end

            S_STEP: begin
                // A single advance cycle; a HALT retiring in it wins the cause.
                state_next = S_DONE;
                cause_next = i_halt_wb ? CAUSE_HALT : CAUSE_STEP;
                if (cmd_any) begin
                    err_next = 1'b1;
                end
            end

            S_DRAIN: begin
                if (i_halt_wb) begin
                    state_next = S_DONE;
                    cause_next = CAUSE_HALT;
                end else if (drain_cnt == 4'd0) begin
                    state_next = S_DONE;
                end else begin
                    drain_cnt_next = drain_cnt - 4'd1;
                end
                if (cmd_any) begin
                    err_next = 1'b1;
                end
            end

            S_DONE: begin
                if (cmd_stop) begin
                    state_next = S_IDLE;
                    cause_next = CAUSE_HALT;
                end else if (cmd_run || cmd_step) begin
                    if (cause == CAUSE_HALT) begin
                        // Program has halted; only STOP can leave.
                        err_next = 1'b1;
                    end else if (cmd_run) begin
                        state_next   = S_RUN;
                        skip_bp_next = (cause == CAUSE_BP);
                    end else begin
                        state_next = S_STEP;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered Moore outputs derived from the state being entered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cmd_ready <= 1'b1;
            o_cmd_err   <= 1'b0;
            o_pipe_en   <= 1'b0;
            o_fetch_en  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_cmd_ready <= 1'b1;
            o_cmd_err   <= err_next;
            o_pipe_en   <= (state_next == S_RUN) || (state_next == S_STEP) ||
                           (state_next == S_DRAIN);
            o_fetch_en  <= (state_next == S_RUN) || (state_next == S_STEP);
            o_busy      <= (state_next == S_RUN) || (state_next == S_STEP) ||
                           (state_next == S_DRAIN);
            o_done      <= (state_next == S_DONE) && (state != S_DONE);
        end
    end

    assign o_halt_cause = cause;

    // Saturating count of cycles in which the pipeline advanced.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cycle_cnt <= '0;
        end else if (clear_cnt) begin
            o_cycle_cnt <= '0;
        end else if (o_pipe_en && (o_cycle_cnt != '1)) begin
            o_cycle_cnt <= o_cycle_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
